// File: rtl/pipe_add_if.sv
// Handshake bundle for the pipelined adder: an input stream (operands plus
// control) and an output stream (result plus flags).
interface pipe_add_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipe_add.sv
// Pipelined add/subtract: each stage resolves one WIDTH/STAGES-bit slice with
// 4-bit carry-lookahead groups and hands the carry to the next stage.
module pipe_add #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  pipe_add_if.slave  bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;
  localparam int L  = STAGES - 1;

  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Lookahead inside each nibble, ripple from nibble to nibble.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW-1:0] s;
    logic          c;
    logic [4:0]    r;
    s = '0;
    c = ci;
    for (int g = 0; g < NG; g++) begin
      r          = cla4(x[4*g +: 4], y[4*g +: 4], c);
      s[4*g +: 4] = r[3:0];
      c          = r[4];
    end
    return {c, s};
  endfunction

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic              ovf_r;

  logic [STAGES-1:0] load_en;
  logic              take;

  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [SW:0]       sl    [STAGES];
  logic              nxt_ovf;

  // A stage may load if it, or any stage after it, has a hole, or the
  // consumer is draining; this avoids a combinational loop through valid bits.
  always_comb begin
    logic acc;
    load_en = '0;
    acc     = bus.out_ready;
    for (int k = L; k >= 0; k--) begin
      acc        = acc | ~vld[k];
      load_en[k] = acc;
    end
  end

  assign bus.in_ready = ~flush & load_en[0];
  assign take         = bus.in_valid & ~flush & load_en[0];

  // Subtraction is folded in at the input: b and cin are inverted once and
  // the rest of the pipe only ever adds.
  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = bus.sub ? ~bus.b : bus.b;
    src_c    = '0;
    src_c[0] = bus.sub ? ~bus.cin : bus.cin;
    src_s[0] = '0;
    src_v    = '0;
    src_v[0] = take;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_r[k-1];
      src_b[k] = b_r[k-1];
      src_c[k] = c_r[k-1];
      src_s[k] = s_r[k-1];
      src_v[k] = vld[k-1];
    end
    nxt_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      sl[k]               = slice_add(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
      nxt_s[k]            = src_s[k];
      nxt_s[k][k*SW +: SW] = sl[k][SW-1:0];
      nxt_c[k]            = sl[k][SW];
    end
    nxt_ovf = (src_a[L][WIDTH-1] == src_b[L][WIDTH-1]) &
              (nxt_s[L][WIDTH-1] != src_a[L][WIDTH-1]);
  end

  // Stage registers: slice sum merged into forwarded low bits, carry, operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      c_r   <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_en[k]) begin
          a_r[k] <= src_a[k];
          b_r[k] <= src_b[k];
          s_r[k] <= nxt_s[k];
          c_r[k] <= nxt_c[k];
        end
        if (flush)
          vld[k] <= 1'b0;
        else if (load_en[k])
          vld[k] <= src_v[k];
      end
      if (load_en[L])
        ovf_r <= nxt_ovf;
    end
  end

  // Output stage: result fields are forced to zero whenever nothing is presented.
  assign bus.out_valid = vld[L];
  assign bus.sum       = vld[L] ? s_r[L] : '0;
  assign bus.cout      = vld[L] & c_r[L];
  assign bus.ovf       = vld[L] & ovf_r;
  assign bus.zero      = vld[L] & (s_r[L] == '0);

endmodule

// File: doc/pipe_add.md
PIPE_ADD -- requirements
Module: pipe_add

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal: multiple of 4*STAGES, 8..128.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth; legal: 1..8; each stage computes a WIDTH/STAGES-bit slice.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  in  1  synchronous pipeline clear.
REQ-006 SHALL have port in_valid  in  1  input transaction present.
REQ-007 SHALL have port in_ready  out  1  input accepted when in_valid & in_ready at clk edge.
REQ-008 SHALL have port a  in  WIDTH  operand A.
REQ-009 SHALL have port b  in  WIDTH  operand B.
REQ-010 SHALL have port cin  in  1  carry-in (add) / borrow-in (sub).
REQ-011 SHALL have port sub  in  1  0 = add, 1 = subtract.
REQ-012 SHALL have port out_valid  out  1  result present.
REQ-013 SHALL have port out_ready  in  1  consumer accepts result when out_valid & out_ready.
REQ-014 SHALL have port sum  out  WIDTH  result.
REQ-015 SHALL have port cout  out  1  carry out of MSB (sub: 1 = no borrow).
REQ-016 SHALL have port ovf  out  1  signed two's-complement overflow.
REQ-017 SHALL have port zero  out  1  sum == 0.

Function
REQ-018 Add SHALL compute a + b + cin; sub SHALL compute a + ~b + ~cin (= a - b - cin); sub and cin captured with operands.
REQ-019 Slices SHALL use 4-bit carry-lookahead groups, ripple between groups within a slice; inter-slice carry SHALL be registered.
REQ-020 Stage k SHALL compute slice k (LSB first), register its sum bits, carry, and the not-yet-used upper operand bits; completed low sum bits SHALL travel forward unchanged.
REQ-021 Latency SHALL be exactly STAGES cycles from accept to out_valid when out_ready held high; throughput one result/cycle.
REQ-022 Each stage SHALL hold a valid bit; stage k loads when empty or when stage k+1 (or the consumer, for the last stage) takes its contents in the same cycle.
REQ-023 in_ready SHALL equal ~flush & (stage-0 empty | stage 0 advancing); no combinational path from in_valid to in_ready.
REQ-024 Under out_ready low, full pipeline SHALL hold all data stable; out_valid and outputs SHALL not change until handshake; no transaction lost or duplicated.
REQ-025 ovf SHALL be (a_msb == b'_msb) & (sum_msb != a_msb), b' being the effective (possibly inverted) operand.
REQ-026 zero SHALL be computed from the full registered sum in the final stage.
REQ-027 flush SHALL clear all valid bits at the next edge; flush and in_valid in the same cycle: input SHALL not be accepted; flush with out_valid & out_ready: that output counts as consumed, rest discarded.
REQ-028 STAGES=1 SHALL degenerate to a single registered full-width adder with the same handshake.
REQ-029 Data registers with valid = 0 SHALL be don't-care internally, but sum/cout/ovf/zero SHALL read 0 while out_valid = 0.

Reset
REQ-030 rst_n low SHALL immediately clear all valid bits and data registers; out_valid=0, sum=0, cout=0, ovf=0, zero=0; in_ready=1 from first edge after release.
REQ-031 Reset mid-operation SHALL drop all in-flight transactions; none emerge after release.

Verification (WIDTH=32, STAGES=2)
REQ-032 a=0xFFFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> 2 cycles later sum=0x00000000, cout=1, zero=1, ovf=0.
REQ-033 a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1.
REQ-034 Back-to-back stream 1+1, 2+2, 3+3 with out_ready=1 -> out_valid on 3 consecutive cycles, sums 2, 4, 6 in order.
REQ-035 out_ready=0, 4 offered transactions -> exactly 2 accepted then in_ready=0; outputs stable; out_ready=1 -> both drain in order, then remaining 2 accepted.
REQ-036 2 transactions in flight, flush=1 one cycle -> out_valid=0 next cycle, no stale results later; new input accepted the cycle after flush.
REQ-037 rst_n asserted with pipeline full and out_ready=0 -> outputs 0 immediately, no result appears after release.
